// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Definitions shared by the sequential divider and its step datapath:
//   - state_e   : divider FSM state encoding
//   - cnt_width : bit width of the step counter for a given operand width
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter only has to reach WIDTH-1. It is kept at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// seq_divider_step
//   One restoring-division step (combinational). The partial remainder is
//   shifted left and the next dividend bit is appended, giving T. The divisor
//   is then trial-subtracted through a ripple chain of full adders that
//   computes T + ~D + 1.
//   Ports:
//     rem_i [WIDTH-1:0] : partial remainder before this step
//     bit_i             : next dividend bit (MSB of the quotient shift register)
//     div_i [WIDTH-1:0] : divisor
//     rem_o [WIDTH-1:0] : partial remainder after this step
//     q_o               : quotient bit produced by this step
module seq_divider_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   nd;
  logic [WIDTH+1:0] carry;
  logic [WIDTH-1:0] diff;

  // T keeps every bit of the partial remainder, so the compare is WIDTH+1
  // bits wide and the top bit cannot be lost.
  assign t  = {rem_i, bit_i};
  assign nd = ~{1'b0, div_i};

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      carry[i+1] = (t[i] & nd[i]) | (carry[i] & (t[i] ^ nd[i]));
    end
  end

  always_comb begin
    diff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = t[i] ^ nd[i] ^ carry[i];
    end
  end

  // A carry out of the top bit means there was no borrow, so T >= divisor.
  // In that case T - divisor < divisor, and the difference fits in WIDTH bits.
  assign q_o   = carry[WIDTH+1];
  assign rem_o = q_o ? diff : t[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Iterative unsigned restoring divider. It resolves one quotient bit per
//   clock and sits behind a start/busy/done handshake.
//   Ports:
//     clk                     : system clock, rising edge
//     reset                   : asynchronous, active-high reset
//     start                   : request; accepted in IDLE or DONE only
//     in1 [WIDTH-1:0]         : dividend, captured on the accept edge
//     in2 [WIDTH-1:0]         : divisor, captured on the accept edge
//     busy                    : high while iterating
//     done                    : one-cycle pulse when the results are valid
//     quotient [WIDTH-1:0]    : quotient, held until the next accept
//     remainder [WIDTH-1:0]   : remainder, held until the next accept
//     div_by_zero             : captured divisor was zero; held with the results
//
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | one restoring step per edge, WIDTH steps in total
//   DONE  | results valid for one cycle; start here is accepted back-to-back
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] prem_q,  prem_d;
  logic [WIDTH-1:0] shq_q,   shq_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic             accept;

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (prem_q),
    .bit_i (shq_q[WIDTH-1]),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  assign accept = (state_q != ST_RUN) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    shq_d   = shq_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_RUN: begin
        prem_d = step_rem;
        shq_d  = {shq_q[WIDTH-2:0], step_bit};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          quo_d   = {shq_q[WIDTH-2:0], step_bit};
          rem_d   = step_rem;
        end
      end
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // An accept takes priority over the DONE -> IDLE return.
    if (accept) begin
      dvs_d  = in2;
      shq_d  = in1;
      prem_d = '0;
      cnt_d  = '0;
      if (in2 == '0) begin
        state_d = ST_DONE;
        quo_d   = '1;
        rem_d   = in1;
        dbz_d   = 1'b1;
      end else begin
        state_d = ST_RUN;
        dbz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      shq_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int tests = 0;
  int failed = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference result {quotient, remainder}. A zero divisor gives all ones and the dividend.
  function automatic logic [2*W-1:0] ref_div(input int a, input int b);
    logic [W-1:0] qq, rr;
    if (b == 0) begin
      qq = '1;
      rr = W'(a);
    end else begin
      qq = W'(a / b);
      rr = W'(a % b);
    end
    return {qq, rr};
  endfunction

  // Transaction-level model: an accepted request completes WIDTH edges later.
  // A zero divisor completes on the accept edge itself.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;
  int           m_left = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_q = '0; m_r = '0; m_left = 0;
    end else if (!m_busy && start) begin
      m_a = in1;
      m_b = in2;
      if (in2 == 0) begin
        {m_q, m_r} = ref_div(int'(in1), 0);
        m_done = 1'b1; m_dbz = 1'b1; m_busy = 1'b0;
      end else begin
        m_busy = 1'b1; m_done = 1'b0; m_dbz = 1'b0; m_left = W;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        {m_q, m_r} = ref_div(int'(m_a), int'(m_b));
        m_busy = 1'b0; m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("cyc_busy",   int'(busy),        int'(m_busy));
    chk("cyc_done",   int'(done),        int'(m_done));
    chk("cyc_quot",   int'(quotient),    int'(m_q));
    chk("cyc_rem",    int'(remainder),   int'(m_r));
    chk("cyc_dbz",    int'(div_by_zero), int'(m_dbz));
  end

  task automatic issue(input int a, input int b);
    in1 = W'(a);
    in2 = W'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1 = W'($urandom);
    in2 = W'($urandom);
  endtask

  // n0 counts the edges already passed since the accept edge, inclusive.
  task automatic wait_done(input string nm, input int n0, input int eq, input int er,
                           input int edbz, input int en, output int nbusy);
    int n;
    n = n0;
    nbusy = int'(busy);
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      nbusy += int'(busy);
    end
    chk({nm, "_done"},    int'(done),        1);
    chk({nm, "_latency"}, n,                 en);
    chk({nm, "_quot"},    int'(quotient),    eq);
    chk({nm, "_rem"},     int'(remainder),   er);
    chk({nm, "_dbz"},     int'(div_by_zero), edbz);
  endtask

  initial begin
    int nb;
    logic [2*W-1:0] r;

    r = ref_div(13, 3);  chk("model_13_3", int'(r), int'({4'd4, 4'd1}));
    r = ref_div(7, 0);   chk("model_7_0",  int'(r), int'({4'd15, 4'd7}));
    r = ref_div(14, 3);  chk("model_14_3", int'(r), int'({4'd4, 4'd2}));

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quot", int'(quotient), 0);
    chk("rst_rem",  int'(remainder), 0);
    chk("rst_dbz",  int'(div_by_zero), 0);
    reset = 1'b0;
    @(negedge clk);

    issue(13, 3);
    wait_done("d13_3", 1, 4, 1, 0, W + 1, nb);
    chk("d13_3_busycycles", nb, W);
    @(negedge clk);
    chk("d13_3_single_done", int'(done), 0);

    issue(7, 0);
    chk("d7_0_nobusy", int'(busy), 0);
    wait_done("d7_0", 1, 15, 7, 1, 1, nb);
    chk("d7_0_busycycles", nb, 0);
    @(negedge clk);

    issue(15, 1);
    wait_done("d15_1", 1, 15, 0, 0, W + 1, nb);
    issue(2, 5);
    wait_done("b2b_2_5", 1, 0, 2, 0, W + 1, nb);
    @(negedge clk);

    issue(9, 2);
    in1 = 4'd15; in2 = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_done("ign_9_2", 3, 4, 1, 0, W + 1, nb);
    @(negedge clk);
    chk("ign_single_done", int'(done), 0);

    issue(14, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quot", int'(quotient), 0);
    chk("midrst_rem",  int'(remainder), 0);
    chk("midrst_dbz",  int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_done", int'(done), 0);
    end
    issue(14, 3);
    wait_done("after_rst_14_3", 1, 4, 2, 0, W + 1, nb);
    @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a, b);
        wait_done("sweep", 1, (b == 0) ? 15 : a / b, (b == 0) ? a : a % b,
                  (b == 0) ? 1 : 0, (b == 0) ? 1 : W + 1, nb);
        if (($urandom % 2) == 0) @(negedge clk);
      end
    end

    repeat (3000) begin
      @(negedge clk);
      start = (($urandom % 3) == 0);
      in1 = W'($urandom);
      in2 = (($urandom % 8) == 0) ? '0 : W'($urandom);
      reset = (($urandom % 150) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
